// File: rtl/video_timing_monitor.sv
// video_timing_monitor
//   Checks an incoming video timing stream (hsync/vsync/de/pixel) against a
//   fixed raster. Each phase of a frame has a required symbol, an expected
//   length and an exit symbol. Any deviation flags the phase that broke and
//   drops the monitor back to SEARCH. A frame that completes cleanly pulses
//   frame_done and publishes the sum of its active pixels.
//
// Ports
//   clk            sole clock, one pixel per rising edge
//   rst            asynchronous active-high reset
//   hsync, vsync   sync inputs, polarity set by SYNC_POL
//   de             active-high data enable
//   pixel          pixel data, valid while de is high
//   err_clear      clears err_flags (sticky error bits)
//   locked         last frame clean and no error since
//   frame_done     one-cycle pulse per clean frame
//   frame_count    number of frame_done pulses (wraps)
//   frame_checksum pixel sum of the last clean frame
//   err_flags      [0]VSYNC [1]V_BP [2]HSYNC [3]H_BP [4]ACTIVE [5]H_FP [6]V_FP [7]OVERLAP
//   err_count      number of errors, saturating
module video_timing_monitor #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int SYNC_POL = 0,
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    input  logic [DATA_W-1:0] pixel,
    input  logic              err_clear,
    output logic              locked,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [31:0]       frame_checksum,
    output logic [7:0]        err_flags,
    output logic [15:0]       err_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [23:0] LEN_VSYNC  = 24'(V_SYNC * H_TOTAL);
    localparam logic [23:0] LEN_VBP    = 24'(V_BP * H_TOTAL - H_SYNC - H_BP - H_FP);
    localparam logic [23:0] LEN_HSYNC  = 24'(H_SYNC);
    localparam logic [23:0] LEN_HBP    = 24'(H_BP);
    localparam logic [23:0] LEN_ACTIVE = 24'(H_ACTIVE);
    localparam logic [23:0] LEN_HFP    = 24'(H_FP);
    localparam logic [23:0] LEN_VFP    = 24'(H_FP + V_FP * H_TOTAL);
    localparam logic [9:0]  LAST_LINE  = 10'(V_ACTIVE);
    localparam logic        POL        = (SYNC_POL != 0);

    // State codes double as the err_flags bit index of that phase.
    localparam logic [2:0] ST_VSYNC  = 3'd0;
    localparam logic [2:0] ST_VBP    = 3'd1;
    localparam logic [2:0] ST_HSYNC  = 3'd2;
    localparam logic [2:0] ST_HBP    = 3'd3;
    localparam logic [2:0] ST_ACTIVE = 3'd4;
    localparam logic [2:0] ST_HFP    = 3'd5;
    localparam logic [2:0] ST_VFP    = 3'd6;
    localparam logic [2:0] ST_SEARCH = 3'd7;

    localparam logic [2:0] SYM_I = 3'd0;
    localparam logic [2:0] SYM_V = 3'd1;
    localparam logic [2:0] SYM_H = 3'd2;
    localparam logic [2:0] SYM_D = 3'd3;
    localparam logic [2:0] SYM_X = 3'd4;

    // Registered input samples, stored as "asserted" regardless of polarity.
    logic              hs_reg, vs_reg, de_reg;
    logic [DATA_W-1:0] pix_reg;
    logic              valid_reg;   // low only for the reset-value sample
    logic              armed_reg;   // previous live sample was not S_V

    logic [2:0]  state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next;
    logic [9:0]  line_reg;
    logic [31:0] acc_reg;

    logic [2:0]  sym, req_sym, exit_sym, exit_state;
    logic [23:0] exp_len;
    logic [9:0]  line_inc;
    logic [7:0]  err_set;
    logic        exit_ok, enter_vsync, frame_ok, acc_add;
    logic [31:0] pix_ext;

    assign line_inc = line_reg + 10'd1;
    assign pix_ext  = 32'(pix_reg);

    always_comb begin
        case ({vs_reg, hs_reg, de_reg})
            3'b000:  sym = SYM_I;
            3'b100:  sym = SYM_V;
            3'b010:  sym = SYM_H;
            3'b001:  sym = SYM_D;
            default: sym = SYM_X;
        endcase
    end

    // Per-phase rule table.
    always_comb begin
        req_sym    = SYM_I;
        exit_sym   = SYM_I;
        exp_len    = 24'd1;
        exit_state = ST_SEARCH;
        case (state_reg)
            ST_VSYNC:  begin req_sym = SYM_V; exit_sym = SYM_I; exp_len = LEN_VSYNC;  exit_state = ST_VBP;    end
            ST_VBP:    begin req_sym = SYM_I; exit_sym = SYM_H; exp_len = LEN_VBP;    exit_state = ST_HSYNC;  end
            ST_HSYNC:  begin req_sym = SYM_H; exit_sym = SYM_I; exp_len = LEN_HSYNC;  exit_state = ST_HBP;    end
            ST_HBP:    begin req_sym = SYM_I; exit_sym = SYM_D; exp_len = LEN_HBP;    exit_state = ST_ACTIVE; end
            ST_ACTIVE: begin
                req_sym    = SYM_D;
                exit_sym   = SYM_I;
                exp_len    = LEN_ACTIVE;
                // The line counter advances on this exit, so test its next value.
                exit_state = (line_inc == LAST_LINE) ? ST_VFP : ST_HFP;
            end
            ST_HFP:    begin req_sym = SYM_I; exit_sym = SYM_H; exp_len = LEN_HFP;    exit_state = ST_HSYNC;  end
            ST_VFP:    begin req_sym = SYM_I; exit_sym = SYM_V; exp_len = LEN_VFP;    exit_state = ST_VSYNC;  end
            default:   begin end
        endcase
    end

    // Phase decision on the registered sample.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        err_set     = 8'h00;
        exit_ok     = 1'b0;
        enter_vsync = 1'b0;
        frame_ok    = 1'b0;
        if (valid_reg) begin
            if (state_reg == ST_SEARCH) begin
                if (sym == SYM_V && armed_reg) begin
                    state_next  = ST_VSYNC;
                    cnt_next    = 24'd1;
                    enter_vsync = 1'b1;
                end
            end else if (sym == SYM_X) begin
                err_set[7] = 1'b1;
            end else if (sym == req_sym && cnt_reg != exp_len) begin
                cnt_next = cnt_reg + 24'd1;
            end else if (sym == exit_sym && cnt_reg == exp_len) begin
                exit_ok    = 1'b1;
                state_next = exit_state;
                cnt_next   = 24'd1;
                if (state_reg == ST_VFP) begin
                    enter_vsync = 1'b1;
                    frame_ok    = 1'b1;
                end
            end else begin
                err_set[state_reg] = 1'b1;
            end
            if (err_set != 8'h00) begin
                state_next = ST_SEARCH;
                cnt_next   = 24'd0;
            end
        end
    end

    // Covers the first pixel (accepted on the HBP exit) and the rest of the line.
    assign acc_add = (sym == SYM_D) && (state_next == ST_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_reg         <= 1'b0;
            vs_reg         <= 1'b0;
            de_reg         <= 1'b0;
            pix_reg        <= '0;
            valid_reg      <= 1'b0;
            armed_reg      <= 1'b0;
            state_reg      <= ST_SEARCH;
            cnt_reg        <= 24'd0;
            line_reg       <= 10'd0;
            acc_reg        <= 32'd0;
            locked         <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= 16'd0;
            frame_checksum <= 32'd0;
            err_flags      <= 8'h00;
            err_count      <= 16'd0;
        end else begin
            hs_reg    <= (hsync == POL);
            vs_reg    <= (vsync == POL);
            de_reg    <= de;
            pix_reg   <= pixel;
            valid_reg <= 1'b1;
            armed_reg <= valid_reg && (sym != SYM_V);

            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            if (enter_vsync) begin
                line_reg <= 10'd0;
            end else if (exit_ok && state_reg == ST_ACTIVE) begin
                line_reg <= line_inc;
            end

            if (enter_vsync) begin
                acc_reg <= 32'd0;
            end else if (acc_add) begin
                acc_reg <= acc_reg + pix_ext;
            end

            frame_done <= frame_ok;
            if (frame_ok) begin
                frame_count    <= frame_count + 16'd1;
                frame_checksum <= acc_reg;
                locked         <= 1'b1;
            end

            err_flags <= (err_clear ? 8'h00 : err_flags) | err_set;
            if (err_set != 8'h00) begin
                locked <= 1'b0;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor
//   Drives clean and deliberately broken frames through a small raster.
//   Expected frame_done and error events are queued as the stimulus is
//   generated and compared when the DUT reports them.
module tb_video_timing_monitor;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT      = HA + HFP + HS + HBP;
    localparam int LEN_VS  = VS * HT;
    localparam int LEN_VBP = VBP * HT - HS - HBP - HFP;
    localparam int LEN_VFP = HFP + VFP * HT;

    // Fault kinds for the frame generator.
    localparam int F_NONE = 0, F_HS_SHORT = 1, F_OVERLAP = 2, F_ACT_LONG = 3, F_HFP_CLR = 4, F_STOP = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync, de, err_clear;
    logic [23:0] pixel;
    logic        locked, frame_done;
    logic [15:0] frame_count, err_count;
    logic [31:0] frame_checksum;
    logic [7:0]  err_flags;

    video_timing_monitor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .DATA_W(24)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
        .pixel(pixel), .err_clear(err_clear), .locked(locked),
        .frame_done(frame_done), .frame_count(frame_count),
        .frame_checksum(frame_checksum), .err_flags(err_flags),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fc;
        logic [31:0] sum;
        logic [7:0]  flags;
    } fd_t;

    typedef struct {
        logic [7:0]  flags;
        logic [15:0] ec;
    } er_t;

    fd_t frame_q[$];
    er_t err_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          clr_cycle = -1;
    bit          prev_good = 1'b0;
    logic [31:0] prev_sum = 32'd0;
    logic [15:0] exp_fc = 16'd0;
    logic [15:0] exp_ec = 16'd0;
    logic [7:0]  exp_flags = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle of stimulus; sync inputs are active-low.
    task automatic drive(input bit v, input bit h, input bit d, input logic [23:0] p);
        vsync     = ~v;
        hsync     = ~h;
        de        = d;
        pixel     = p;
        err_clear = (cyc == clr_cycle);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_err(input int idx, input bit clr);
        er_t e;
        exp_flags = (clr ? 8'h00 : exp_flags) | (8'h01 << idx);
        if (exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
        e.flags = exp_flags;
        e.ec    = exp_ec;
        err_q.push_back(e);
    endtask

    task automatic frame(input int fault, input int fline, input int base);
        logic [31:0] acc;
        fd_t         f;
        bit          was_good;
        int          n;
        acc      = 32'd0;
        was_good = prev_good;
        if (prev_good) begin
            exp_fc  = exp_fc + 16'd1;
            f.fc    = exp_fc;
            f.sum   = prev_sum;
            f.flags = exp_flags;
            frame_q.push_back(f);
        end
        prev_good = 1'b0;
        drive(1, 0, 0, 0);
        check("fd_early", 32'(frame_done), 32'd0);
        drive(1, 0, 0, 0);
        check("fd_late", 32'(frame_done), 32'(was_good));
        for (int i = 2; i < LEN_VS; i++) drive(1, 0, 0, 0);
        for (int i = 0; i < LEN_VBP; i++) drive(0, 0, 0, 0);
        for (int ln = 0; ln < VA; ln++) begin
            n = (fault == F_HS_SHORT && ln == fline) ? HS - 1 : HS;
            for (int c = 0; c < n; c++) begin
                if (fault == F_HFP_CLR && ln == fline + 1 && c == 0) begin
                    push_err(5, 1'b1);
                    clr_cycle = cyc + 1;
                end
                if (fault == F_OVERLAP && ln == fline && c == 1) begin
                    push_err(7, 1'b0);
                    drive(0, 1, 1, 0);
                    check("ovl_early", 32'(err_flags[7]), 32'd0);
                end else begin
                    drive(0, 1, 0, 0);
                    if (fault == F_OVERLAP && ln == fline && c == 2)
                        check("ovl_late", 32'(err_flags[7]), 32'd1);
                end
            end
            if (fault == F_HS_SHORT && ln == fline) push_err(2, 1'b0);
            for (int c = 0; c < HBP; c++) drive(0, 0, 0, 0);
            n = (fault == F_ACT_LONG && ln == fline) ? HA + 1 : HA;
            for (int c = 0; c < n; c++) begin
                if (c == HA) push_err(4, 1'b0);
                drive(0, 0, 1, 24'(base + c));
                acc = acc + 32'(base + c);
                if (fault == F_STOP && ln == fline && c == 3) return;
            end
            if (ln < VA - 1) begin
                n = (fault == F_HFP_CLR && ln == fline) ? 1 : HFP;
                for (int c = 0; c < n; c++) drive(0, 0, 0, 0);
            end
        end
        for (int i = 0; i < LEN_VFP; i++) drive(0, 0, 0, 0);
        prev_good = (fault == F_NONE);
        prev_sum  = acc;
    endtask

    // Scoreboard monitor: output events are popped and compared here.
    initial begin
        logic [15:0] prev_ec;
        fd_t         f;
        er_t         e;
        prev_ec = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_done) begin
                    if (frame_q.size() == 0) begin
                        check("fd_unexpected", 32'(frame_done), 32'd0);
                    end else begin
                        f = frame_q.pop_front();
                        $display("frame_done: count=%0d checksum=0x%0h flags=0x%0h locked=%0d",
                                 frame_count, frame_checksum, err_flags, locked);
                        check("fd_count", 32'(frame_count), 32'(f.fc));
                        check("fd_checksum", frame_checksum, f.sum);
                        check("fd_locked", 32'(locked), 32'd1);
                        check("fd_flags", 32'(err_flags), 32'(f.flags));
                    end
                end
                if (err_count != prev_ec) begin
                    if (err_q.size() == 0) begin
                        check("err_unexpected", 32'(err_count), 32'(prev_ec));
                    end else begin
                        e = err_q.pop_front();
                        $display("error: flags=0x%0h count=%0d locked=%0d", err_flags, err_count, locked);
                        check("err_flags", 32'(err_flags), 32'(e.flags));
                        check("err_count", 32'(err_count), 32'(e.ec));
                        check("err_locked", 32'(locked), 32'd0);
                    end
                end
            end
            prev_ec = err_count;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; vsync = 1'b1; hsync = 1'b1; de = 1'b0; pixel = '0; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_sum", frame_checksum, 32'd0);
        check("rst_flags", 32'(err_flags), 32'd0);
        check("rst_ec", 32'(err_count), 32'd0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);

        // Three clean frames.
        for (int k = 0; k < 3; k++) frame(F_NONE, 0, 0);
        check("a_fc", 32'(frame_count), 32'd2);
        check("a_sum", frame_checksum, 32'h70);
        check("a_locked", 32'(locked), 32'd1);
        check("a_flags", 32'(err_flags), 32'd0);

        // Short hsync, then recovery with the sticky flag kept.
        frame(F_HS_SHORT, 1, 0);
        check("b_flags", 32'(err_flags), 32'h04);
        check("b_ec", 32'(err_count), 32'd1);
        check("b_locked", 32'(locked), 32'd0);
        frame(F_NONE, 0, 0);
        frame(F_OVERLAP, 0, 0);
        check("c_flags", 32'(err_flags), 32'h84);
        check("c_locked", 32'(locked), 32'd0);

        // Long active line, preceded by a frame with offset pixels.
        frame(F_NONE, 0, 'h100);
        frame(F_ACT_LONG, 2, 0);
        check("d_flags", 32'(err_flags), 32'h94);
        check("d_ec", 32'(err_count), 32'd3);

        // err_clear coinciding with a front-porch error.
        frame(F_NONE, 0, 0);
        frame(F_HFP_CLR, 0, 0);
        check("e_flags", 32'(err_flags), 32'h20);
        check("e_ec", 32'(err_count), 32'd4);

        // Asynchronous reset mid-line while locked.
        frame(F_NONE, 0, 0);
        frame(F_STOP, 1, 0);
        check("f_prelock", 32'(locked), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("f_locked", 32'(locked), 32'd0);
        check("f_fd", 32'(frame_done), 32'd0);
        check("f_fc", 32'(frame_count), 32'd0);
        check("f_sum", frame_checksum, 32'd0);
        check("f_flags", 32'(err_flags), 32'd0);
        check("f_ec", 32'(err_count), 32'd0);
        frame_q.delete();
        err_q.delete();
        exp_fc = 16'd0; exp_ec = 16'd0; exp_flags = 8'h00; prev_good = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        rst = 1'b0;
        // vsync already asserted across reset release must not start a frame.
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0);
        frame(F_NONE, 0, 0);
        check("g_fc0", 32'(frame_count), 32'd0);
        frame(F_NONE, 0, 7);
        frame(F_STOP, 0, 0);
        push_err(4, 1'b0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
        check("g_fc", 32'(frame_count), 32'd2);
        check("g_sum", frame_checksum, 32'h150);
        check("sb_frames_left", 32'(frame_q.size()), 32'd0);
        check("sb_errors_left", 32'(err_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_monitor.md
VIDEO_TIMING_MONITOR -- requirements
Module: video_timing_monitor

Interface
REQ-001 Parameter H_ACTIVE, 1024: visible pixels per line.
REQ-002 Parameter H_FP, 24; H_SYNC, 136; H_BP, 160: horizontal porch and sync lengths in clocks.
REQ-003 Parameter V_ACTIVE, 768; V_FP, 3; V_SYNC, 6; V_BP, 29: vertical lengths in lines.
REQ-004 Parameter SYNC_POL, 0: 0 means hsync/vsync are active-low, 1 means active-high.
REQ-005 Parameter DATA_W, 24: pixel width, 1..32.
REQ-006 Port clk, input, 1: sole clock; one pixel per rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port hsync, vsync, de, input, 1 each: video timing signals; de is active-high.
REQ-009 Port pixel, input, DATA_W: pixel data, valid while de is asserted.
REQ-010 Port err_clear, input, 1: clears err_flags.
REQ-011 Port locked, output, 1: last frame was error-free and no error has occurred since.
REQ-012 Port frame_done, output, 1: single-cycle pulse on each completed error-free frame.
REQ-013 Port frame_count, output, 16: count of frame_done pulses, wraps at 16 bits.
REQ-014 Port frame_checksum, output, 32: pixel checksum of the last good frame.
REQ-015 Port err_flags, output, 8: sticky flags, bit order [0] VSYNC, [1] V_BP, [2] HSYNC, [3] H_BP, [4] ACTIVE, [5] H_FP, [6] V_FP, [7] OVERLAP.
REQ-016 Port err_count, output, 16: count of errors, saturates at 0xFFFF.

Function
REQ-017 hsync, vsync, de and pixel SHALL be registered once; all decisions SHALL use the registered samples; outputs SHALL respond 2 clk after the input edge.
REQ-018 Each registered sample SHALL decode to one symbol:
- S_V: only vsync asserted.
- S_H: only hsync asserted.
- S_D: only de asserted.
- S_I: none asserted.
- S_X: more than one asserted.
REQ-019 FSM states SHALL be SEARCH, VSYNC, VBP, HSYNC, HBP, ACTIVE, HFP and VFP.
REQ-020 Phase counter SHALL be 24 bits, SHALL be 1 on the first cycle of a phase, and SHALL increment each cycle; all parameter products SHALL be < 2^24.
REQ-021 Each state SHALL have a required symbol, expected length and exit symbol:
- VSYNC: S_V for V_SYNC*H_TOTAL cycles, exit S_I into VBP.
- VBP: S_I for V_BP*H_TOTAL - H_SYNC - H_BP - H_FP cycles, exit S_H into HSYNC.
- HSYNC: S_H for H_SYNC cycles, exit S_I into HBP.
- HBP: S_I for H_BP cycles, exit S_D into ACTIVE.
- ACTIVE: S_D for H_ACTIVE cycles, exit S_I into HFP, or into VFP after line V_ACTIVE.
- HFP: S_I for H_FP cycles, exit S_H into HSYNC.
- VFP: S_I for H_FP + V_FP*H_TOTAL cycles, exit S_V into VSYNC.
- H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-022 A correct-length exit SHALL move to the next state and reset the counter to 1.
REQ-023 The following SHALL be a phase error of the current state:
- the exit symbol arrives with counter != expected;
- the required symbol is still present with counter == expected;
- any other symbol appears.
REQ-024 On an S_X sample outside SEARCH, OVERLAP SHALL be flagged instead of the phase error.
REQ-025 On any error the block SHALL:
- set the matching err_flags bit;
- increment err_count;
- clear locked;
- enter SEARCH.
REQ-026 In SEARCH the block SHALL flag nothing and SHALL enter VSYNC with counter 1 on the first S_V that follows a non-S_V sample.
REQ-027 A 10-bit line counter SHALL reset on VSYNC entry, SHALL increment on each ACTIVE exit, and SHALL select VFP when it equals V_ACTIVE.
REQ-028 The checksum accumulator SHALL clear on VSYNC entry and SHALL add zero-extended pixel mod 2^32 on every ACTIVE cycle.
REQ-029 A correct VFP-to-VSYNC exit SHALL, in the same cycle:
- pulse frame_done;
- increment frame_count;
- load frame_checksum from the accumulator;
- set locked.
REQ-030 When err_clear and a new error occur in the same cycle, the new error's bit SHALL be set and all other bits cleared.
REQ-031 err_clear SHALL affect only err_flags.

Reset
REQ-032 rst SHALL asynchronously force the following:
- FSM to SEARCH;
- counters and input registers to 0;
- locked, frame_done and err_flags to 0;
- frame_count, frame_checksum and err_count to 0.
REQ-033 After rst is released, the first frame SHALL be detected only from the next vsync assertion edge.

Verification
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, SYNC_POL=0, DATA_W=24, with pixel = column index.
REQ-034 Three correct frames -> frame_done at each of the 2nd and 3rd vsync edges, frame_count=2, frame_checksum=0x70, locked=1 after first pulse, err_flags=0.
REQ-035 HSYNC 2 clk on line 2 -> err_flags=0x04, err_count=1, locked=0; next full frame -> locked=1 with flag still set.
REQ-036 de asserted during an hsync cycle -> err_flags[7]=1 2 clk later, FSM in SEARCH.
REQ-037 ACTIVE held 9 clk -> err_flags[4] set on the 9th registered de sample, no frame_done that frame.
REQ-038 err_clear pulsed in the same cycle as an H_FP error -> err_flags=0x20.
REQ-039 rst asserted mid-line in locked state -> all outputs 0 immediately; no frame_done until one vsync-to-vsync frame completes.
